banco_registros: RTL and testbench
==================================

# banco_registros

MIPS general-purpose register file: the receiving end of the write-back stage. It accepts the write-back port (`i_write_reg`, `i_write_data`, `i_RegWrite`) and serves the two combinational read ports used by decode. Register $0 is hardwired to zero. A same-cycle write-to-read bypass is included. A valid/ready debug port streams all 32 registers to the debug unit on request.

## Interface
- `LEN`, 32, data width of each register
- `NB_ADDRESS_REGISTROS`, 5, register address width; depth is 2**NB_ADDRESS_REGISTROS
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_read_reg_1`  in  NB_ADDRESS_REGISTROS  read port 1 address (rs)
- `i_read_reg_2`  in  NB_ADDRESS_REGISTROS  read port 2 address (rt)
- `o_read_data_1`  out  LEN  read port 1 data, combinational
- `o_read_data_2`  out  LEN  read port 2 data, combinational
- `i_write_reg`  in  NB_ADDRESS_REGISTROS  write-back destination
- `i_write_data`  in  LEN  write-back data
- `i_RegWrite`  in  1  write enable from write-back
- `i_debug_start`  in  1  pulse: begin register dump
- `i_debug_ready`  in  1  debug sink ready
- `o_debug_valid`  out  1  `o_debug_data`/`o_debug_addr` valid
- `o_debug_data`  out  LEN  dumped register value, registered
- `o_debug_addr`  out  NB_ADDRESS_REGISTROS  index of dumped register
- `o_debug_last`  out  1  current beat is the final register
- `o_debug_busy`  out  1  dump in progress

## Operation
- Storage: 2**NB_ADDRESS_REGISTROS x LEN flops.
- Write: on the rising edge with `i_RegWrite`=1 and `i_write_reg`!=0, `reg[i_write_reg]` <= `i_write_data`. Writes to $0 are discarded.
- Read: `o_read_data_n` is 0 if the address is 0.
  - Otherwise, if `i_RegWrite`=1 and `i_write_reg` equals the address, the output is `i_write_data` (bypass).
  - Otherwise the output is `reg[addr]`.
  - Reads are purely combinational.
- Debug FSM has two states, IDLE and DUMP, with a 5-bit index `idx`.
  - IDLE to DUMP: on `i_debug_start`=1. Load `idx`=0, `o_debug_addr`=0, `o_debug_data`=0, `o_debug_valid`=1.
  - DUMP, beat accepted (`o_debug_valid`=1 and `i_debug_ready`=1):
    - If `idx`=31: go to IDLE and set `o_debug_valid`=0.
    - Otherwise: `idx`++, `o_debug_addr`<=idx+1, and `o_debug_data` <= the bypassed read value of idx+1 in that cycle.
  - DUMP with `i_debug_ready`=0: all debug outputs hold stable. A write to the displayed register does not alter the held beat.
  - `i_debug_start` is ignored while in DUMP.
- `o_debug_last` = DUMP and `idx`=31. `o_debug_busy` = (state == DUMP).
- Normal reads and writes are unaffected by the dump.

## Timing
- Reset (asynchronous): all registers 0, state IDLE, `idx`=0.
  - `o_debug_valid`=0, `o_debug_data`=0, `o_debug_addr`=0, `o_debug_last`=0, `o_debug_busy`=0.
  - Read outputs are 0, because the storage is 0 and the bypass is gated by `i_RegWrite`.
- Read latency is 0 cycles. Write is visible to reads in the same cycle through the bypass, and from storage from the next cycle.
- The first debug beat is valid 1 cycle after the `i_debug_start` edge.
- With `i_debug_ready` held high, the dump takes exactly 32 consecutive valid cycles.
- Reset asserted mid-dump: the FSM returns to IDLE immediately and `o_debug_valid` drops asynchronously. A later `i_debug_start` restarts at index 0.
- Simultaneous `i_debug_start` and reset: reset wins.

## Test plan
- Reset then read: assert `i_rst` with random `i_read_reg_1`/`i_read_reg_2` -> both outputs 0. All debug outputs 0.
- Write/read with bypass:
  - Write `i_write_reg`=5, `i_write_data`=0xDEADBEEF, `i_RegWrite`=1 with `i_read_reg_1`=5 -> `o_read_data_1`=0xDEADBEEF in the same cycle.
  - After the edge with `i_RegWrite`=0 -> still 0xDEADBEEF.
- $0 protection: write 0x12345678 to reg 0, then read reg 0 on both ports -> 0. Verify both in the same cycle (bypass suppressed) and in the next cycle.
- Full dump, ready high: preload reg[i]=i*0x01010101, pulse `i_debug_start`.
  - Expect 32 consecutive beats with `o_debug_addr`=0..31 and `o_debug_data`=reg[i].
  - `o_debug_last` is high only at addr 31. `o_debug_busy` falls after the last beat.
- Backpressure: drop `i_debug_ready` at addr 7 for 4 cycles while writing reg 7=0xAAAA5555.
  - The beat holds addr 7 with its pre-write data.
  - A write to reg 8 during the stall appears in the addr-8 beat.
- Reset mid-dump: assert `i_rst` at addr 12 -> `o_debug_valid`=0 immediately. A new `i_debug_start` restarts at addr 0. A start pulse mid-dump is ignored (addresses continue in sequence).

Source files
------------

// File: rtl/banco_registros_if.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros_if
// Description : Bus bundle for the MIPS register file. It carries the
//               write-back port, the two decode read ports and the
//               valid/ready debug dump stream.
//               master : write-back / decode / debug-sink side
//               slave  : the register file itself
// Revision    : 1.0 - initial release
// ============================================================================
interface banco_registros_if #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5
);
    // Decode read ports
    logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg_1;
    logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg_2;
    logic [LEN-1:0]                  o_read_data_1;
    logic [LEN-1:0]                  o_read_data_2;

    // Write-back port
    logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg;
    logic [LEN-1:0]                  i_write_data;
    logic                            i_RegWrite;

    // Debug dump stream
    logic                            i_debug_start;
    logic                            i_debug_ready;
    logic                            o_debug_valid;
    logic [LEN-1:0]                  o_debug_data;
    logic [NB_ADDRESS_REGISTROS-1:0] o_debug_addr;
    logic                            o_debug_last;
    logic                            o_debug_busy;

    modport master (
        output i_read_reg_1, i_read_reg_2,
        output i_write_reg, i_write_data, i_RegWrite,
        output i_debug_start, i_debug_ready,
        input  o_read_data_1, o_read_data_2,
        input  o_debug_valid, o_debug_data, o_debug_addr,
        input  o_debug_last, o_debug_busy
    );

    modport slave (
        input  i_read_reg_1, i_read_reg_2,
        input  i_write_reg, i_write_data, i_RegWrite,
        input  i_debug_start, i_debug_ready,
        output o_read_data_1, o_read_data_2,
        output o_debug_valid, o_debug_data, o_debug_addr,
        output o_debug_last, o_debug_busy
    );
endinterface
`default_nettype wire

// File: rtl/banco_registros.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros
// Description : MIPS general-purpose register file. $0 is hardwired to zero,
//               both read ports are combinational with a same-cycle
//               write-to-read bypass, and a valid/ready debug port streams
//               all registers in index order on request.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - asynchronous active-high reset
//               bus    - banco_registros_if.slave (read, write-back, debug)
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registros #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    banco_registros_if.slave  bus
);
    localparam int                              c_DEPTH     = 1 << NB_ADDRESS_REGISTROS;
    localparam logic [NB_ADDRESS_REGISTROS-1:0] c_ADDR_ZERO = '0;
    localparam logic [NB_ADDRESS_REGISTROS-1:0] c_LAST_IDX  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    logic [LEN-1:0]                  r_regs [c_DEPTH];
    state_t                          r_state;
    state_t                          w_state_next;
    logic [NB_ADDRESS_REGISTROS-1:0] r_idx;
    logic [NB_ADDRESS_REGISTROS-1:0] w_idx_next;
    logic [NB_ADDRESS_REGISTROS-1:0] w_idx_plus1;
    logic [LEN-1:0]                  r_debug_data;
    logic [LEN-1:0]                  w_debug_data_next;
    logic [LEN-1:0]                  w_dump_read;

    // Read rule shared by all three read paths: $0 reads zero, a write in
    // flight to the same address wins over storage.
    function automatic logic [LEN-1:0] f_read(
        input logic [NB_ADDRESS_REGISTROS-1:0] addr,
        input logic                            we,
        input logic [NB_ADDRESS_REGISTROS-1:0] waddr,
        input logic [LEN-1:0]                  wdata,
        input logic [LEN-1:0]                  stored
    );
        if (addr == c_ADDR_ZERO) begin
            return '0;
        end else if (we && (waddr == addr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.i_RegWrite && (bus.i_write_reg != c_ADDR_ZERO)) begin
            r_regs[bus.i_write_reg] <= bus.i_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Decode read ports
    // ------------------------------------------------------------------
    assign bus.o_read_data_1 = f_read(bus.i_read_reg_1, bus.i_RegWrite, bus.i_write_reg,
                                      bus.i_write_data, r_regs[bus.i_read_reg_1]);
    assign bus.o_read_data_2 = f_read(bus.i_read_reg_2, bus.i_RegWrite, bus.i_write_reg,
                                      bus.i_write_data, r_regs[bus.i_read_reg_2]);

    // Third read path: fetches the next beat so a write landing in the same
    // cycle the current beat is accepted is still reflected in the dump.
    assign w_idx_plus1 = r_idx + 1'b1;
    assign w_dump_read = f_read(w_idx_plus1, bus.i_RegWrite, bus.i_write_reg,
                                bus.i_write_data, r_regs[w_idx_plus1]);

    // ------------------------------------------------------------------
    // Debug dump FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_debug_data <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_debug_data <= w_debug_data_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_debug_data_next = r_debug_data;
        case (r_state)
            ST_IDLE: begin
                // Beat 0 is $0, which is always zero, so no read is needed.
                if (bus.i_debug_start) begin
                    w_state_next      = ST_DUMP;
                    w_idx_next        = '0;
                    w_debug_data_next = '0;
                end
            end
            ST_DUMP: begin
                // Without ready the beat is frozen, including its data, even
                // if the displayed register is overwritten meanwhile.
                if (bus.i_debug_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next        = w_idx_plus1;
                        w_debug_data_next = w_dump_read;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // valid follows the state register directly, so an asynchronous reset
    // drops it without waiting for a clock edge.
    assign bus.o_debug_valid = (r_state == ST_DUMP);
    assign bus.o_debug_busy  = (r_state == ST_DUMP);
    assign bus.o_debug_last  = (r_state == ST_DUMP) && (r_idx == c_LAST_IDX);
    assign bus.o_debug_addr  = r_idx;
    assign bus.o_debug_data  = r_debug_data;

endmodule
`default_nettype wire

// File: tb/tb_banco_registros.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registros
// Description : Self-checking bench for banco_registros: reset state, a
//               table of read/write/bypass vectors, random traffic against a
//               register-array model, and hand-written debug dump sequences
//               (full dump, backpressure, reset mid-dump, ignored start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registros;
    localparam int LEN   = 32;
    localparam int NB    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banco_registros_if #(.LEN(LEN), .NB_ADDRESS_REGISTROS(NB)) bus ();

    banco_registros #(.LEN(LEN), .NB_ADDRESS_REGISTROS(NB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [DEPTH];

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference read: zero register, then in-flight write, then stored value.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.i_RegWrite && (bus.i_write_reg == a)) return bus.i_write_data;
        return model[a];
    endfunction

    // Crosses one rising edge, commits the model, returns at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        end else if (bus.i_RegWrite && (bus.i_write_reg != 5'd0)) begin
            model[bus.i_write_reg] = bus.i_write_data;
        end
        @(negedge clk);
    endtask

    task automatic check_reads(input string name);
        #1;
        check({name, "_rd1"}, bus.o_read_data_1, ref_read(bus.i_read_reg_1));
        check({name, "_rd2"}, bus.o_read_data_2, ref_read(bus.i_read_reg_2));
    endtask

    task automatic check_beat(input int k, input logic [31:0] exp_data);
        #1;
        check($sformatf("beat%0d_valid", k), 32'(bus.o_debug_valid), 32'd1);
        check($sformatf("beat%0d_addr", k),  32'(bus.o_debug_addr), 32'(k));
        check($sformatf("beat%0d_data", k),  bus.o_debug_data, exp_data);
        check($sformatf("beat%0d_last", k),  32'(bus.o_debug_last), (k == 31) ? 32'd1 : 32'd0);
        check($sformatf("beat%0d_busy", k),  32'(bus.o_debug_busy), 32'd1);
    endtask

    task automatic check_debug_idle(input string name);
        #1;
        check({name, "_valid"}, 32'(bus.o_debug_valid), 32'd0);
        check({name, "_busy"},  32'(bus.o_debug_busy), 32'd0);
        check({name, "_last"},  32'(bus.o_debug_last), 32'd0);
    endtask

    task automatic start_dump();
        bus.i_debug_start = 1'b1;
        next_cycle();
        bus.i_debug_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            we    wr     wd             r1     r2     e1             e2
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'hFFFFFFFF};
        vecs[6] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd31, 32'h00000001, 32'hFFFFFFFF};

        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

        // Reset, with a start pulse present that reset must override.
        rst               = 1'b1;
        bus.i_read_reg_1  = 5'($urandom);
        bus.i_read_reg_2  = 5'($urandom);
        bus.i_write_reg   = 5'd0;
        bus.i_write_data  = 32'd0;
        bus.i_RegWrite    = 1'b0;
        bus.i_debug_start = 1'b0;
        bus.i_debug_ready = 1'b1;
        #1;
        check("reset_rd1", bus.o_read_data_1, 32'd0);
        check("reset_rd2", bus.o_read_data_2, 32'd0);
        check("reset_dbg_data", bus.o_debug_data, 32'd0);
        check("reset_dbg_addr", 32'(bus.o_debug_addr), 32'd0);
        check_debug_idle("reset");
        @(negedge clk);
        bus.i_debug_start = 1'b1;
        next_cycle();
        check_debug_idle("reset_vs_start");
        bus.i_debug_start = 1'b0;
        rst = 1'b0;
        next_cycle();

        // Table vectors: bypass, $0 protection, write-then-read.
        for (int i = 0; i < 7; i++) begin
            bus.i_RegWrite   = vecs[i].we;
            bus.i_write_reg  = vecs[i].wr;
            bus.i_write_data = vecs[i].wd;
            bus.i_read_reg_1 = vecs[i].r1;
            bus.i_read_reg_2 = vecs[i].r2;
            #1;
            check($sformatf("vec%0d_rd1", i), bus.o_read_data_1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.o_read_data_2, vecs[i].e2);
            next_cycle();
        end

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            bus.i_RegWrite   = 1'($urandom_range(0, 1));
            bus.i_write_reg  = 5'($urandom);
            bus.i_write_data = $urandom;
            bus.i_read_reg_1 = 5'($urandom);
            bus.i_read_reg_2 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) bus.i_read_reg_1 = bus.i_write_reg;
            if ($urandom_range(0, 3) == 0) bus.i_read_reg_2 = bus.i_write_reg;
            check_reads($sformatf("rand%0d", i));
            next_cycle();
        end

        // Preload reg[i] = i * 0x01010101.
        for (int i = 1; i < DEPTH; i++) begin
            bus.i_RegWrite   = 1'b1;
            bus.i_write_reg  = 5'(i);
            bus.i_write_data = 32'(i) * 32'h01010101;
            next_cycle();
        end
        bus.i_RegWrite = 1'b0;

        // Full dump with ready held high: 32 consecutive beats.
        start_dump();
        for (int k = 0; k < DEPTH; k++) begin
            check_beat(k, 32'(k) * 32'h01010101);
            next_cycle();
        end
        check_debug_idle("after_dump");

        // Backpressure at beat 7 while registers 7 and 8 are rewritten.
        start_dump();
        for (int k = 0; k < 7; k++) begin
            check_beat(k, model[k]);
            next_cycle();
        end
        bus.i_debug_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.i_RegWrite   = (s == 0) || (s == 2);
            bus.i_write_reg  = (s == 0) ? 5'd7 : 5'd8;
            bus.i_write_data = (s == 0) ? 32'hAAAA5555 : 32'h88888888;
            check_beat(7, 32'h07070707);
            next_cycle();
        end
        bus.i_RegWrite    = 1'b0;
        bus.i_debug_ready = 1'b1;
        bus.i_read_reg_1  = 5'd7;
        bus.i_read_reg_2  = 5'd8;
        #1;
        check("stall_rd_reg7", bus.o_read_data_1, 32'hAAAA5555);
        check("stall_rd_reg8", bus.o_read_data_2, 32'h88888888);
        check_beat(7, 32'h07070707);
        next_cycle();
        for (int k = 8; k < DEPTH; k++) begin
            check_beat(k, model[k]);
            next_cycle();
        end
        check_debug_idle("after_stall_dump");

        // Start ignored mid-dump, then reset at beat 12.
        start_dump();
        for (int k = 0; k < 12; k++) begin
            bus.i_debug_start = (k == 5);
            check_beat(k, model[k]);
            next_cycle();
        end
        bus.i_debug_start = 1'b0;
        check_beat(12, model[12]);
        rst = 1'b1;
        #1;
        check_debug_idle("async_reset");
        check("async_reset_addr", 32'(bus.o_debug_addr), 32'd0);
        check("async_reset_data", bus.o_debug_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        start_dump();
        for (int k = 0; k < DEPTH; k++) begin
            check_beat(k, 32'd0);
            next_cycle();
        end
        check_debug_idle("after_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
